pipe_stage_reg_n: RTL and testbench
===================================

Name: pipe_stage_reg_n

Overview:
- Parametrised, elastic successor to the fixed EX/MEM register.
- A DEPTH-slice pipeline register carrying an opaque DATA_W payload, with per-slice valid bits and a valid/ready handshake.
- Global stall (enable) and flush controls, plus a sticky halt that travels with the payload.
- Placed between any two datapath stages (ID/EX, EX/MEM, MEM/WB); also used where a multi-cycle functional unit needs extra retiming slices.

Parameters:
- DATA_W, 32, payload width in bits (1..256).
- DEPTH, 1, number of register slices (1..4); slice 0 is input side, slice DEPTH-1 is output side.
- OCC_W, $clog2(DEPTH+1), width of the occupancy output (derived; do not override).

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  reset, synchronous, active-high.
- enable  input  1  0 = stall: no slice changes, in_ready=0 (hazard unit / dhit wait).
- flush  input  1  1 = squash all slices this edge (branch/jump resolution).
- in_valid  input  1  upstream has a payload.
- in_ready  output  1  slice 0 can accept this cycle.
- in_data  input  DATA_W  payload.
- in_halt  input  1  payload is a halt instruction.
- out_valid  output  1  slice DEPTH-1 holds a payload.
- out_ready  input  1  downstream consumes this cycle.
- out_data  output  DATA_W  slice DEPTH-1 payload.
- out_halt  output  1  halt flag of slice DEPTH-1.
- halted  output  1  sticky: a halt payload has been consumed.
- occupancy  output  OCC_W  count of valid slices.

Behaviour:
- Reset (RST=1 at edge): all valid bits, data and halt flags = 0; halted=0; occupancy=0. Reset overrides flush and enable. Reset mid-transfer discards all contents; no partial payload survives.
- Per slice i: v[i], d[i], h[i].
- move[DEPTH-1] = v[DEPTH-1] & out_ready & enable & !flush.
- move[i] for i<DEPTH-1 = v[i] & (!v[i+1] | move[i+1]) & enable & !flush.
- in_ready = enable & !flush & !halted & (!v[0] | move[0]). Combinational, with the ready chain from out_ready.
- Accept = in_valid & in_ready. Slice 0 loads in_data/in_halt and sets v[0].
- Slice i+1 loads from slice i when move[i]. A slice whose contents leave and receive nothing clears its valid bit.
- Latency: a payload accepted at edge N is out_valid after edge N+DEPTH-1 (visible in cycle N+DEPTH-1 after the accepting edge), assuming no stalls.
- Throughput: one payload per cycle when out_ready is held at 1.
- Bubbles compress: an empty slice ahead of a valid slice is filled even when out_ready=0.
- enable=0: all state held, in_ready=0, outputs stable. out_valid may still be 1, but consumption does not occur.
- flush=1 (enable ignored): at the edge, all v=0, d=0, h=0. in_ready=0 that cycle, so no payload is accepted. A payload presented with out_ready=1 that cycle is NOT consumed.
- halted: set at the edge where out_valid & out_halt & out_ready & enable & !flush; cleared only by RST. Once set, in_ready stays 0 and already-held slices still drain.
- occupancy = popcount(v), registered alongside v. Range 0..DEPTH; it never wraps.
- Full (occupancy=DEPTH) with out_ready=0: in_ready=0.
- Full with out_ready=1: accept and drain in the same cycle; occupancy is unchanged.
- out_data and out_halt are 0 whenever out_valid=0.

Optional Feature:
- Macro PIPE_STAGE_PERF_EN.
- When defined, adds three outputs:
  - stall_cnt (32): cycles with in_valid & !in_ready.
  - flush_cnt (16): edges with flush=1 and occupancy>0.
  - xfer_cnt (32): consumed payloads.
- Counters saturate at all-ones, reset to 0 on RST, and never wrap.
- When undefined, these ports and counters do not exist, and the rest of the block behaves identically.

Test Plan:
- DEPTH=2, enable=1, out_ready=1; stream in_data 0x11, 0x22, 0x33 on consecutive cycles -> out_data 0x11, 0x22, 0x33 on consecutive cycles, first one cycle after the accepting edge; occupancy stays at 2.
- DEPTH=3, out_ready=0, push 0xA0, 0xA1, 0xA2, 0xA3 -> first three accepted, in_ready=0 on the fourth, occupancy=3; raise out_ready -> 0xA0 emerges and 0xA3 is accepted in the same cycle.
- DEPTH=2, two slices valid (0x5, 0x6), flush=1 with in_valid=1 and out_ready=1 -> next cycle occupancy=0, out_valid=0, out_data=0; neither 0x5 nor the input payload is transferred.
- enable=0 for 3 cycles with slices holding 0x7, 0x8 and out_ready=1 -> outputs frozen, in_ready=0; on re-enable, 0x7 exits first.
- Payload 0xDEAD with in_halt=1, then 0xBEEF -> halted=1 after 0xDEAD is consumed; 0xBEEF never accepted; RST=1 for one edge -> halted=0, in_ready=1.
- With PIPE_STAGE_PERF_EN: 5 stall cycles, 2 non-empty flushes, 7 transfers -> stall_cnt=5, flush_cnt=2, xfer_cnt=7; all counters 0 after RST.

Source files
------------

// File: rtl/pipe_stage_reg_n_if.sv
// rtl/pipe_stage_reg_n_if.sv - valid/ready payload handshake with halt flag for pipe_stage_reg_n
interface pipe_stage_reg_n_if #(
  parameter int DATA_W = 32
) ();
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic              halt;

  modport master (output valid, output data, output halt, input ready);
  modport slave  (input valid, input data, input halt, output ready);
endinterface

// File: rtl/pipe_stage_reg_n.sv
// rtl/pipe_stage_reg_n.sv - elastic DEPTH-slice pipeline register, stall/flush, sticky halt (optional counters: PIPE_STAGE_PERF_EN)
module pipe_stage_reg_n #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1,
  parameter int OCC_W  = $clog2(DEPTH + 1)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               enable,
  input  logic               flush,
  pipe_stage_reg_n_if.slave  up,
  pipe_stage_reg_n_if.master dn,
  output logic               halted,
  output logic [OCC_W-1:0]   occupancy
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]        stall_cnt,
  output logic [15:0]        flush_cnt,
  output logic [31:0]        xfer_cnt
`endif
);

  logic                         run;
  logic                         in_rdy;
  logic                         accept;
  logic [DEPTH-1:0]             v_q, v_n;
  logic [DEPTH-1:0]             h_q, h_n;
  logic [DEPTH-1:0]             mv;
  logic [DEPTH-1:0][DATA_W-1:0] d_q, d_n;
  logic [OCC_W-1:0]             occ_n;

  assign run    = enable & ~flush;
  assign in_rdy = run & ~halted & (~v_q[0] | mv[0]);
  assign accept = up.valid & in_rdy;

  assign up.ready = in_rdy;
  assign dn.valid = v_q[DEPTH-1];
  assign dn.data  = v_q[DEPTH-1] ? d_q[DEPTH-1] : '0;
  assign dn.halt  = v_q[DEPTH-1] & h_q[DEPTH-1];

  // Ready chain: a slice advances when the one ahead is empty or advancing too
  always_comb begin
    mv = '0;
    mv[DEPTH-1] = v_q[DEPTH-1] & dn.ready & run;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      mv[i] = v_q[i] & (~v_q[i+1] | mv[i+1]) & run;
    end
  end

  // Next slice contents: flush squashes everything, otherwise shift along the move chain
  always_comb begin
    v_n = v_q;
    h_n = h_q;
    d_n = d_q;
    if (flush) begin
      v_n = '0;
      h_n = '0;
      d_n = '0;
    end else begin
      for (int i = 1; i < DEPTH; i++) begin
        if (mv[i-1]) begin
          v_n[i] = 1'b1;
          d_n[i] = d_q[i-1];
          h_n[i] = h_q[i-1];
        end else if (mv[i]) begin
          v_n[i] = 1'b0;
        end
      end
      if (accept) begin
        v_n[0] = 1'b1;
        d_n[0] = up.data;
        h_n[0] = up.halt;
      end else if (mv[0]) begin
        v_n[0] = 1'b0;
      end
    end
    occ_n = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ_n = occ_n + OCC_W'(v_n[i]);
    end
  end

  // Slice state and occupancy registered together so they never disagree
  always_ff @(posedge CLK) begin
    if (RST) begin
      v_q       <= '0;
      h_q       <= '0;
      d_q       <= '0;
      occupancy <= '0;
    end else begin
      v_q       <= v_n;
      h_q       <= h_n;
      d_q       <= d_n;
      occupancy <= occ_n;
    end
  end

  // Sticky halt once a halt payload is actually consumed downstream
  always_ff @(posedge CLK) begin
    if (RST) begin
      halted <= 1'b0;
    end else if (mv[DEPTH-1] && h_q[DEPTH-1]) begin
      halted <= 1'b1;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  // Saturating event counters
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
      xfer_cnt  <= '0;
    end else begin
      if (up.valid && !in_rdy && stall_cnt != '1) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (flush && occupancy != '0 && flush_cnt != '1) begin
        flush_cnt <= flush_cnt + 16'd1;
      end
      if (mv[DEPTH-1] && xfer_cnt != '1) begin
        xfer_cnt <= xfer_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg_n.sv
// tb/tb_pipe_stage_reg_n.sv - directed self-checking bench for pipe_stage_reg_n (DEPTH=2 and DEPTH=3)
module tb_pipe_stage_reg_n;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       RST;
  logic       en2, fl2, en3, fl3;
  logic       halted2, halted3;
  logic [1:0] occ2, occ3;
  int         n_chk = 0;
  int         n_fail = 0;

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] st2, x2, st3, x3;
  logic [15:0] f2, f3;
`endif

  pipe_stage_reg_n_if #(.DATA_W(32)) a2_up ();
  pipe_stage_reg_n_if #(.DATA_W(32)) a2_dn ();
  pipe_stage_reg_n_if #(.DATA_W(8))  a3_up ();
  pipe_stage_reg_n_if #(.DATA_W(8))  a3_dn ();

  pipe_stage_reg_n #(.DEPTH(2)) u2 (
    .CLK(CLK), .RST(RST), .enable(en2), .flush(fl2),
    .up(a2_up), .dn(a2_dn), .halted(halted2), .occupancy(occ2)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt(st2), .flush_cnt(f2), .xfer_cnt(x2)
`endif
  );

  pipe_stage_reg_n #(.DATA_W(8), .DEPTH(3)) u3 (
    .CLK(CLK), .RST(RST), .enable(en3), .flush(fl3),
    .up(a3_up), .dn(a3_dn), .halted(halted3), .occupancy(occ3)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt(st3), .flush_cnt(f3), .xfer_cnt(x3)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1;
    en2 = 1'b1; fl2 = 1'b0; en3 = 1'b1; fl3 = 1'b0;
    a2_up.valid = 1'b0; a2_up.data = '0; a2_up.halt = 1'b0; a2_dn.ready = 1'b1;
    a3_up.valid = 1'b0; a3_up.data = '0; a3_up.halt = 1'b0; a3_dn.ready = 1'b0;
    tick();
    RST = 1'b0;
    #1;
    chk("rst_occ", 64'(occ2), 64'd0);
    chk("rst_out_valid", 64'(a2_dn.valid), 64'd0);
    chk("rst_out_data", 64'(a2_dn.data), 64'd0);
    chk("rst_halted", 64'(halted2), 64'd0);
    chk("rst_in_ready", 64'(a2_up.ready), 64'd1);
    chk("rst_occ3", 64'(occ3), 64'd0);

    // streaming, DEPTH=2, out_ready=1
    a2_up.valid = 1'b1; a2_up.data = 32'h11;
    tick();
    chk("s_e1_occ", 64'(occ2), 64'd1);
    chk("s_e1_valid", 64'(a2_dn.valid), 64'd0);
    a2_up.data = 32'h22;
    tick();
    chk("s_e2_valid", 64'(a2_dn.valid), 64'd1);
    chk("s_e2_data", 64'(a2_dn.data), 64'h11);
    chk("s_e2_occ", 64'(occ2), 64'd2);
    a2_up.data = 32'h33;
    tick();
    chk("s_e3_data", 64'(a2_dn.data), 64'h22);
    chk("s_e3_occ", 64'(occ2), 64'd2);
    a2_up.valid = 1'b0;
    tick();
    chk("s_e4_data", 64'(a2_dn.data), 64'h33);
    chk("s_e4_occ", 64'(occ2), 64'd1);
    tick();
    chk("s_e5_valid", 64'(a2_dn.valid), 64'd0);
    chk("s_e5_data", 64'(a2_dn.data), 64'd0);
    chk("s_e5_occ", 64'(occ2), 64'd0);

    // fill DEPTH=3 with out_ready=0, then drain while accepting
    a3_up.valid = 1'b1; a3_up.data = 8'hA0;
    tick();
    a3_up.data = 8'hA1;
    tick();
    a3_up.data = 8'hA2;
    tick();
    chk("f_full_occ", 64'(occ3), 64'd3);
    chk("f_full_valid", 64'(a3_dn.valid), 64'd1);
    chk("f_full_data", 64'(a3_dn.data), 64'hA0);
    a3_up.data = 8'hA3;
    #1;
    chk("f_full_in_ready", 64'(a3_up.ready), 64'd0);
    tick();
    chk("f_hold_occ", 64'(occ3), 64'd3);
    chk("f_hold_data", 64'(a3_dn.data), 64'hA0);
    a3_dn.ready = 1'b1;
    #1;
    chk("f_drain_in_ready", 64'(a3_up.ready), 64'd1);
    tick();
    chk("f_d1_data", 64'(a3_dn.data), 64'hA1);
    chk("f_d1_occ", 64'(occ3), 64'd3);
    a3_up.valid = 1'b0;
    tick();
    chk("f_d2_data", 64'(a3_dn.data), 64'hA2);
    chk("f_d2_occ", 64'(occ3), 64'd2);
    tick();
    chk("f_d3_data", 64'(a3_dn.data), 64'hA3);
    chk("f_d3_occ", 64'(occ3), 64'd1);
    tick();
    chk("f_d4_valid", 64'(a3_dn.valid), 64'd0);
    chk("f_d4_occ", 64'(occ3), 64'd0);
    a3_dn.ready = 1'b0;

    // flush with two held payloads, input offered and out_ready=1
    a2_dn.ready = 1'b0;
    a2_up.valid = 1'b1; a2_up.data = 32'h5;
    tick();
    a2_up.data = 32'h6;
    tick();
    chk("fl_pre_occ", 64'(occ2), 64'd2);
    chk("fl_pre_data", 64'(a2_dn.data), 64'h5);
    a2_up.data = 32'h99; a2_dn.ready = 1'b1; fl2 = 1'b1;
    #1;
    chk("fl_in_ready", 64'(a2_up.ready), 64'd0);
    tick();
    chk("fl_occ", 64'(occ2), 64'd0);
    chk("fl_valid", 64'(a2_dn.valid), 64'd0);
    chk("fl_data", 64'(a2_dn.data), 64'd0);
    fl2 = 1'b0; a2_up.valid = 1'b0;
    tick();
    chk("fl_after_occ", 64'(occ2), 64'd0);

    // stall for three cycles with 0x7, 0x8 held
    a2_dn.ready = 1'b0;
    a2_up.valid = 1'b1; a2_up.data = 32'h7;
    tick();
    a2_up.data = 32'h8;
    tick();
    en2 = 1'b0; a2_dn.ready = 1'b1; a2_up.data = 32'h9;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("st_in_ready", 64'(a2_up.ready), 64'd0);
      tick();
      chk("st_data", 64'(a2_dn.data), 64'h7);
      chk("st_occ", 64'(occ2), 64'd2);
    end
    en2 = 1'b1; a2_up.valid = 1'b0;
    #1;
    chk("st_re_data", 64'(a2_dn.data), 64'h7);
    tick();
    chk("st_re1_data", 64'(a2_dn.data), 64'h8);
    chk("st_re1_occ", 64'(occ2), 64'd1);
    tick();
    chk("st_re2_occ", 64'(occ2), 64'd0);

    // halt payload, then a payload that must be refused
    a2_dn.ready = 1'b0;
    a2_up.valid = 1'b1; a2_up.data = 32'hDEAD; a2_up.halt = 1'b1;
    tick();
    a2_up.valid = 1'b0; a2_up.halt = 1'b0;
    tick();
    chk("h_out_halt", 64'(a2_dn.halt), 64'd1);
    chk("h_out_data", 64'(a2_dn.data), 64'hDEAD);
    chk("h_not_yet", 64'(halted2), 64'd0);
    a2_dn.ready = 1'b1;
    tick();
    chk("h_halted", 64'(halted2), 64'd1);
    chk("h_occ", 64'(occ2), 64'd0);
    a2_up.valid = 1'b1; a2_up.data = 32'hBEEF;
    #1;
    chk("h_in_ready", 64'(a2_up.ready), 64'd0);
    tick();
    tick();
    chk("h_beef_occ", 64'(occ2), 64'd0);
    chk("h_beef_valid", 64'(a2_dn.valid), 64'd0);
    RST = 1'b1;
    tick();
    RST = 1'b0; a2_up.valid = 1'b0;
    #1;
    chk("h_rst_halted", 64'(halted2), 64'd0);
    chk("h_rst_in_ready", 64'(a2_up.ready), 64'd1);

`ifdef PIPE_STAGE_PERF_EN
    en2 = 1'b0; a2_up.valid = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    en2 = 1'b1; a2_dn.ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      a2_up.data = 32'(k + 1);
      tick();
    end
    a2_up.valid = 1'b0;
    tick();
    tick();
    a2_dn.ready = 1'b0; fl2 = 1'b1;
    tick();
    fl2 = 1'b0; a2_up.valid = 1'b1; a2_up.data = 32'h55;
    tick();
    a2_up.valid = 1'b0; fl2 = 1'b1;
    tick();
    fl2 = 1'b0; a2_up.valid = 1'b1;
    tick();
    a2_up.valid = 1'b0; fl2 = 1'b1;
    tick();
    fl2 = 1'b0;
    chk("p_stall_cnt", 64'(st2), 64'd5);
    chk("p_flush_cnt", 64'(f2), 64'd2);
    chk("p_xfer_cnt", 64'(x2), 64'd7);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("p_rst_stall", 64'(st2), 64'd0);
    chk("p_rst_flush", 64'(f2), 64'd0);
    chk("p_rst_xfer", 64'(x2), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
